fabric_mem_slave: RTL and testbench
===================================

FABRIC_MEM_SLAVE -- requirements
Module: fabric_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fabric address width.
REQ-002 SHALL have parameter DATA_W, default 32, fabric data width (8, 16, 32 or 64).
REQ-003 SHALL have parameters ID_W, OP_W, SIZE_W, ATTR_W, CODE_W, defaults 4, 8, 3, CARBON_FABRIC_ATTR_WIDTH_BITS, 8, fabric field widths.
REQ-004 SHALL have parameter MEM_AW, default 10, memory word-address width.
REQ-005 SHALL have parameter WAIT_CYCLES, default 0, extra stall cycles before each memory access (0..15).
REQ-006 SHALL have parameters OP_READ, default 0, and OP_WRITE, default 1, accepted req_op encodings.
REQ-007 SHALL have parameters CODE_OK, default 0, and CODE_ERR, default 1, response codes.
REQ-008 clk  input  1  single clock, rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 bus  fabric_if.slave  -  one fabric port: req_valid/ready/op/addr/wdata/wstrb/size/attr/id in; rsp_valid/ready/rdata/code/id out.
REQ-011 mem_en  output  1  synchronous-SRAM access strobe.
REQ-012 mem_we  output  1  write enable, qualified by mem_en.
REQ-013 mem_addr  output  MEM_AW  word address.
REQ-014 mem_wdata / mem_wstrb  output  DATA_W / DATA_W/8  write data and byte enables.
REQ-015 mem_rdata  input  DATA_W  read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, ACCESS, CAPTURE, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; no other state accepts a request.
REQ-018 On req_valid&&req_ready SHALL capture op, addr, wdata, wstrb, size, id; LSB=log2(DATA_W/8); word address = addr[LSB+MEM_AW-1:LSB]; higher bits ignored (aliasing).
REQ-019 Request SHALL be an error if: op not OP_READ/OP_WRITE; or 2^size > DATA_W/8; or addr not aligned to 2^size.
REQ-020 Error request: IDLE->RESP next cycle, rsp_code=CODE_ERR, rsp_rdata=0, no mem_en pulse.
REQ-021 Good request: IDLE->WAIT if WAIT_CYCLES>0 else ->ACCESS; WAIT counts exactly WAIT_CYCLES cycles then ->ACCESS.
REQ-022 ACCESS: mem_en=1 for exactly one cycle with captured address; write drives mem_we=1, mem_wdata, mem_wstrb=captured wstrb (no size masking); read drives mem_we=0, mem_wstrb=0.
REQ-023 Write: ACCESS->RESP; read: ACCESS->CAPTURE, which registers mem_rdata, ->RESP.
REQ-024 RESP: rsp_valid=1, rsp_id=captured id, rsp_code=CODE_OK, rsp_rdata=registered read data (0 for writes); all held stable until rsp_ready.
REQ-025 rsp_valid&&rsp_ready SHALL return FSM to IDLE; next request accepted no earlier than following cycle.
REQ-026 Accept-to-rsp_valid latency: write 2+WAIT_CYCLES, read 3+WAIT_CYCLES, error 1 cycle.
REQ-027 rsp_valid SHALL NOT depend combinationally on rsp_ready; req_ready SHALL NOT depend combinationally on req_valid.
REQ-028 mem_en SHALL be 0 in every state except ACCESS; at most one outstanding transaction.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, WAIT counter 0, captured fields and read-data register 0.
REQ-030 During reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_code=0, rsp_id=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
REQ-031 Reset mid-transaction SHALL abandon it silently; no response issued after release.
REQ-032 First cycle after rst_n release SHALL be IDLE with req_ready=1.

Verification
REQ-033 WAIT_CYCLES=0, DATA_W=32: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, id 3 -> mem_en/mem_we at cycle+1, mem_addr 4; rsp_valid cycle+2, code CODE_OK, id 3.
REQ-034 Read back addr 0x10, id 5, SRAM model returns 0xDEADBEEF -> rsp_valid at accept+3, rsp_rdata 0xDEADBEEF, id 5, mem_we=0.
REQ-035 WAIT_CYCLES=3 read -> mem_en exactly at accept+4, rsp_valid at accept+6, req_ready 0 throughout.
REQ-036 Size 2 (word) at addr 0x2, and op 0x7 at addr 0x0 -> each: rsp_valid at accept+1, CODE_ERR, rdata 0, no mem_en.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata/code/id stable; req_valid asserted meanwhile not accepted.
REQ-038 Assert rst_n=0 in WAIT -> all outputs zero immediately; after release no response, req_ready=1.

Source files
------------

// File: rtl/fabric_mem_slave.sv
// fabric_mem_slave: single-port fabric slave that bridges fabric requests onto
// a synchronous SRAM. One transaction is in flight at a time. A request is
// validated, optionally stalled for WAIT_CYCLES cycles, and then issued as one
// SRAM access. Its response is held until the initiator accepts it.
//
// Ports
//   clk, rst_n        clock (rising edge); asynchronous active-low reset
//   req_*             fabric request: valid/ready handshake plus op, addr,
//                     wdata, wstrb, size (log2 bytes), attr (ignored), id
//   rsp_*             fabric response: valid/ready handshake plus rdata, code, id
//   mem_en / mem_we   SRAM strobe and write enable (we is qualified by en)
//   mem_addr          SRAM word address
//   mem_wdata/wstrb   SRAM write data and byte enables
//   mem_rdata         SRAM read data, valid the cycle after a read strobe

`ifndef CARBON_FABRIC_ATTR_WIDTH_BITS
`define CARBON_FABRIC_ATTR_WIDTH_BITS 8
`endif

module fabric_mem_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter int OP_W        = 8,
    parameter int SIZE_W      = 3,
    parameter int ATTR_W      = `CARBON_FABRIC_ATTR_WIDTH_BITS,
    parameter int CODE_W      = 8,
    parameter int MEM_AW      = 10,
    parameter int WAIT_CYCLES = 0,
    parameter int OP_READ     = 0,
    parameter int OP_WRITE    = 1,
    parameter int CODE_OK     = 0,
    parameter int CODE_ERR    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    // fabric request
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_W-1:0]     req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [SIZE_W-1:0]   req_size,
    input  logic [ATTR_W-1:0]   req_attr,
    input  logic [ID_W-1:0]     req_id,
    // fabric response
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [CODE_W-1:0]   rsp_code,
    output logic [ID_W-1:0]     rsp_id,
    // SRAM
    output logic                mem_en,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int LSB = $clog2(DATA_W / 8);
    // The counter is loaded with WAIT_CYCLES-1 so that WAIT lasts exactly
    // WAIT_CYCLES cycles, including the one in which it reaches zero.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                state_reg;
    logic [3:0]            wait_cnt_reg;
    logic                  is_write_reg;
    logic [MEM_AW-1:0]     addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W/8-1:0]   wstrb_reg;
    logic                  req_ready_reg;
    logic                  rsp_valid_reg;
    logic [DATA_W-1:0]     rsp_rdata_reg;
    logic [CODE_W-1:0]     rsp_code_reg;
    logic [ID_W-1:0]       rsp_id_reg;
    logic                  mem_en_reg;
    logic                  mem_we_reg;
    logic [MEM_AW-1:0]     mem_addr_reg;
    logic [DATA_W-1:0]     mem_wdata_reg;
    logic [DATA_W/8-1:0]   mem_wstrb_reg;

    // Request decode. Address bits above the memory window alias onto it.
    logic                  req_is_write;
    logic                  op_ok;
    logic                  size_ok;
    logic                  align_ok;
    logic                  req_err;
    logic [ADDR_W-1:0]     align_mask;
    logic [MEM_AW-1:0]     req_word;

    always_comb begin
        req_is_write = (req_op == OP_W'(OP_WRITE));
        op_ok        = (req_op == OP_W'(OP_READ)) || req_is_write;
        size_ok      = (32'(req_size) <= 32'(LSB));
        align_mask   = ~({ADDR_W{1'b1}} << req_size);
        align_ok     = ((req_addr & align_mask) == '0);
        req_err      = !(op_ok && size_ok && align_ok);
        req_word     = req_addr[LSB +: MEM_AW];
    end

    // Attributes and the out-of-window address bits have no effect here.
    logic unused_ok;
    assign unused_ok = ^{req_attr, req_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            is_write_reg  <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_code_reg  <= '0;
            rsp_id_reg    <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        is_write_reg  <= req_is_write;
                        addr_reg      <= req_word;
                        wdata_reg     <= req_wdata;
                        wstrb_reg     <= req_wstrb;
                        rsp_id_reg    <= req_id;
                        if (req_err) begin
                            state_reg     <= S_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_code_reg  <= CODE_W'(CODE_ERR);
                            rsp_rdata_reg <= '0;
                        end else if (WAIT_CYCLES > 0) begin
                            state_reg    <= S_WAIT;
                            wait_cnt_reg <= WAIT_INIT;
                        end else begin
                            // No stall: strobe the SRAM straight from the request.
                            state_reg     <= S_ACCESS;
                            mem_en_reg    <= 1'b1;
                            mem_we_reg    <= req_is_write;
                            mem_addr_reg  <= req_word;
                            mem_wdata_reg <= req_wdata;
                            mem_wstrb_reg <= req_is_write ? req_wstrb : '0;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset release.
                        req_ready_reg <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg     <= S_ACCESS;
                        mem_en_reg    <= 1'b1;
                        mem_we_reg    <= is_write_reg;
                        mem_addr_reg  <= addr_reg;
                        mem_wdata_reg <= wdata_reg;
                        mem_wstrb_reg <= is_write_reg ? wstrb_reg : '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                S_ACCESS: begin
                    mem_en_reg    <= 1'b0;
                    mem_we_reg    <= 1'b0;
                    mem_wstrb_reg <= '0;
                    if (is_write_reg) begin
                        state_reg     <= S_RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_code_reg  <= CODE_W'(CODE_OK);
                        rsp_rdata_reg <= '0;
                    end else begin
                        state_reg <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    state_reg     <= S_RESP;
                    rsp_valid_reg <= 1'b1;
                    rsp_code_reg  <= CODE_W'(CODE_OK);
                    rsp_rdata_reg <= mem_rdata;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= S_IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_code  = rsp_code_reg;
    assign rsp_id    = rsp_id_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;

endmodule

// File: tb/tb_fabric_mem_slave.sv
// Testbench for fabric_mem_slave: a zero-wait instance driven from a table of
// directed vectors, and a three-wait-cycle instance used for the stall and
// reset-in-WAIT sequences. Both share one SRAM model.
module tb_fabric_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [7:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_size;
    logic [7:0]  req_attr;
    logic [3:0]  req_id;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, mem_en0, mem_we0;
    logic [31:0] rsp_rdata0, mem_wdata0, mem_rdata0;
    logic [7:0]  rsp_code0;
    logic [3:0]  rsp_id0, mem_wstrb0;
    logic [9:0]  mem_addr0;

    logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, mem_en1, mem_we1;
    logic [31:0] rsp_rdata1, mem_wdata1, mem_rdata1;
    logic [7:0]  rsp_code1;
    logic [3:0]  rsp_id1, mem_wstrb1;
    logic [9:0]  mem_addr1;

    fabric_mem_slave #(.ATTR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_size(req_size), .req_attr(req_attr), .req_id(req_id),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .rsp_code(rsp_code0), .rsp_id(rsp_id0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_wstrb(mem_wstrb0), .mem_rdata(mem_rdata0)
    );

    fabric_mem_slave #(.ATTR_W(8), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_size(req_size), .req_attr(req_attr), .req_id(req_id),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
        .rsp_code(rsp_code1), .rsp_id(rsp_id1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1), .mem_rdata(mem_rdata1)
    );

    // SRAM model: one-cycle read latency, byte-enabled writes (dut0 only writes).
    logic [31:0] sram [0:1023] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en0) begin
            if (mem_we0) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb0[b]) sram[mem_addr0][8*b +: 8] <= mem_wdata0[8*b +: 8];
            end else begin
                mem_rdata0 <= sram[mem_addr0];
            end
        end
        if (mem_en1 && !mem_we1) mem_rdata1 <= sram[mem_addr1];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  size;
        logic [3:0]  id;
        int          lat;
        logic [7:0]  code;
        logic [31:0] rdata;
        int          n_en;
        logic [9:0]  maddr;
        logic        we;
    } vec_t;

    vec_t vecs [11];

    // Issue one request on dut0 and check latency, response fields and the SRAM strobe.
    task automatic run_vec(input int idx, input vec_t v);
        int lat, n_en, guard;
        logic [9:0] seen_addr;
        logic seen_we;
        logic got;
        guard = 0;
        while (!req_ready0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("v%0d_req_ready", idx), req_ready0, 1);
        req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        req_wstrb = v.wstrb; req_size = v.size; req_id = v.id;
        req_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        lat = 1; n_en = 0; got = 1'b0; seen_addr = '0; seen_we = 1'b0;
        while (lat <= 20) begin
            if (mem_en0) begin
                n_en++;
                seen_addr = mem_addr0;
                seen_we = mem_we0;
            end
            if (rsp_valid0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_rsp_seen", idx), got, 1);
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_code", idx), rsp_code0, v.code);
        chk($sformatf("v%0d_rdata", idx), rsp_rdata0, v.rdata);
        chk($sformatf("v%0d_id", idx), rsp_id0, v.id);
        chk($sformatf("v%0d_mem_en_count", idx), n_en, v.n_en);
        if (v.n_en > 0) begin
            chk($sformatf("v%0d_mem_addr", idx), seen_addr, v.maddr);
            chk($sformatf("v%0d_mem_we", idx), seen_we, v.we);
        end
        $display("txn %0d op=%0h addr=%08h size=%0d id=%0h lat=%0d code=%0h rdata=%08h",
                 idx, v.op, v.addr, v.size, v.id, lat, rsp_code0, rsp_rdata0);
        rsp_ready0 = 1'b1;
        @(negedge clk);
        rsp_ready0 = 1'b0;
        chk($sformatf("v%0d_rsp_dropped", idx), rsp_valid0, 0);
        chk($sformatf("v%0d_ready_again", idx), req_ready0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, en_first, en_count, rsp_cyc, ready_bad, bad;
        logic [31:0] snap_rdata;
        logic [7:0]  snap_code;
        logic [3:0]  snap_id;

        //                op     addr          wdata         strb  sz  id  lat code   rdata         en maddr    we
        vecs[0]  = '{8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 4'h3, 2, 8'h00, 32'h0,         1, 10'h004, 1'b1};
        vecs[1]  = '{8'h00, 32'h0000_0010, 32'h0,         4'hF, 3'd2, 4'h5, 3, 8'h00, 32'hDEAD_BEEF, 1, 10'h004, 1'b0};
        vecs[2]  = '{8'h00, 32'h0000_0002, 32'h0,         4'h0, 3'd2, 4'h1, 1, 8'h01, 32'h0,         0, 10'h000, 1'b0};
        vecs[3]  = '{8'h07, 32'h0000_0000, 32'h0,         4'h0, 3'd2, 4'h2, 1, 8'h01, 32'h0,         0, 10'h000, 1'b0};
        vecs[4]  = '{8'h01, 32'h0000_0021, 32'h0000_AA00, 4'h2, 3'd0, 4'h4, 2, 8'h00, 32'h0,         1, 10'h008, 1'b1};
        vecs[5]  = '{8'h00, 32'h0000_0020, 32'h0,         4'h0, 3'd2, 4'h6, 3, 8'h00, 32'h0000_AA00, 1, 10'h008, 1'b0};
        vecs[6]  = '{8'h00, 32'h0000_0000, 32'h0,         4'h0, 3'd3, 4'hC, 1, 8'h01, 32'h0,         0, 10'h000, 1'b0};
        vecs[7]  = '{8'h00, 32'h0000_0003, 32'h0,         4'h0, 3'd1, 4'hD, 1, 8'h01, 32'h0,         0, 10'h000, 1'b0};
        vecs[8]  = '{8'h01, 32'h0000_0042, 32'h1234_0000, 4'hC, 3'd1, 4'h7, 2, 8'h00, 32'h0,         1, 10'h010, 1'b1};
        vecs[9]  = '{8'h00, 32'h0000_1042, 32'h0,         4'h0, 3'd1, 4'h8, 3, 8'h00, 32'h1234_0000, 1, 10'h010, 1'b0};
        vecs[10] = '{8'h02, 32'h0000_0004, 32'h0,         4'h0, 3'd2, 4'hE, 1, 8'h01, 32'h0,         0, 10'h000, 1'b0};

        rst_n = 1'b0;
        req_valid0 = 1'b0; req_valid1 = 1'b0; rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
        req_op = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        req_size = '0; req_attr = 8'h5A; req_id = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready0, 0);
        chk("reset_rsp_valid", rsp_valid0, 0);
        chk("reset_mem_en", mem_en0, 0);
        chk("reset_rsp_rdata", rsp_rdata0, 0);
        chk("reset_rsp_code", rsp_code0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready0", req_ready0, 1);
        chk("post_reset_ready1", req_ready1, 1);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Three wait cycles: strobe at accept+4, response at accept+6.
        req_op = 8'h00; req_addr = 32'h10; req_size = 3'd2; req_id = 4'hA;
        req_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid1 = 1'b0;
        en_first = 0; en_count = 0; rsp_cyc = 0; ready_bad = 0;
        for (cyc = 1; cyc <= 12; cyc++) begin
            if (mem_en1) begin
                en_count++;
                if (en_first == 0) en_first = cyc;
            end
            if (rsp_valid1) begin
                rsp_cyc = cyc;
                break;
            end
            if (req_ready1) ready_bad++;
            @(negedge clk);
        end
        chk("wait3_mem_en_cycle", en_first, 4);
        chk("wait3_mem_en_count", en_count, 1);
        chk("wait3_rsp_cycle", rsp_cyc, 6);
        chk("wait3_ready_low", ready_bad, 0);
        chk("wait3_rdata", rsp_rdata1, 32'hDEAD_BEEF);
        chk("wait3_id", rsp_id1, 4'hA);
        $display("txn wait3 read addr=00000010 en_cycle=%0d rsp_cycle=%0d rdata=%08h",
                 en_first, rsp_cyc, rsp_rdata1);
        rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0;

        // Backpressure: response held five cycles while another request waits.
        req_op = 8'h00; req_addr = 32'h10; req_size = 3'd2; req_id = 4'h9;
        req_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        cyc = 0;
        while (!rsp_valid0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_rsp_seen", rsp_valid0, 1);
        snap_rdata = rsp_rdata0; snap_code = rsp_code0; snap_id = rsp_id0;
        chk("bp_rdata", snap_rdata, 32'hDEAD_BEEF);
        req_op = 8'h01; req_addr = 32'h80; req_wdata = 32'h5555_5555; req_wstrb = 4'hF; req_id = 4'h1;
        req_valid0 = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!rsp_valid0 || rsp_rdata0 !== snap_rdata || rsp_code0 !== snap_code ||
                rsp_id0 !== snap_id || req_ready0 || mem_en0) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_id_held", rsp_id0, 4'h9);
        req_valid0 = 1'b0;
        rsp_ready0 = 1'b1;
        @(negedge clk);
        rsp_ready0 = 1'b0;
        chk("bp_ready_after", req_ready0, 1);
        $display("txn backpressure id=9 held 5 cycles rdata=%08h", snap_rdata);

        // Reset while dut1 sits in WAIT: outputs clear at once, transaction dropped.
        req_op = 8'h00; req_addr = 32'h10; req_size = 3'd2; req_id = 4'hB;
        req_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_req_ready", req_ready1, 0);
        chk("rst_wait_rsp_valid", rsp_valid1, 0);
        chk("rst_wait_rsp_rdata", rsp_rdata1, 0);
        chk("rst_wait_rsp_code", rsp_code1, 0);
        chk("rst_wait_rsp_id", rsp_id1, 0);
        chk("rst_wait_mem_en", mem_en1, 0);
        chk("rst_wait_mem_we", mem_we1, 0);
        chk("rst_wait_mem_addr", mem_addr1, 0);
        chk("rst_wait_mem_wdata", mem_wdata1, 0);
        chk("rst_wait_mem_wstrb", mem_wstrb1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wait_ready_after", req_ready1, 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid1 || mem_en1) bad++;
            @(negedge clk);
        end
        chk("rst_wait_no_response", bad, 0);
        $display("txn reset-in-wait id=B abandoned");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
